// File: rtl/ram_byte_sequencer_if.sv
// Control-unit request/response and byte-RAM signals of the byte sequencer.
// The slave modport is the sequencer; the master side is the control unit plus the RAM array.
interface ram_byte_sequencer_if #(
  parameter int ADDR_W = 9
) ();
  logic              MFA;
  logic              RW;
  logic [1:0]        Size;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              AlignErr;
  logic              Busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [7:0]        ram_rdata;

  modport slave (
    input  MFA, RW, Size, Address, DataIn, ram_rdata,
    output DataOut, MOC, AlignErr, Busy, ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output MFA, RW, Size, Address, DataIn, ram_rdata,
    input  DataOut, MOC, AlignErr, Busy, ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/ram_byte_sequencer.sv
// Splits word/halfword/byte requests into big-endian single-byte RAM accesses; MOC after N+2 (read) / N+1 (write) cycles.
// MOC/AlignErr are held while MFA stays high; a new request needs MFA low for one edge.
module ram_byte_sequencer #(
  parameter int ADDR_W = 9
) (
  input logic                  Clk,
  input logic                  Clear,
  ram_byte_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       wsh_q, wsh_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       dout_q, dout_d;
  logic              bad;

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      wsh_q   <= 32'h0;
      asm_q   <= 32'h0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wsh_q   <= wsh_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wsh_d   = wsh_q;
    asm_d   = asm_q;
    dout_d  = dout_q;
    bad     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.MFA) begin
          addr_d = bus.Address;
          rw_d   = bus.RW;
          cnt_d  = 2'd0;
          asm_d  = 32'h0;
          // Write data is left-justified so the next byte out is always wsh_q[31:24].
          unique case (bus.Size)
            2'b00: begin
              last_d = 2'd0;
              wsh_d  = {bus.DataIn[7:0], 24'h0};
            end
            2'b01: begin
              last_d = 2'd1;
              wsh_d  = {bus.DataIn[15:0], 16'h0};
              bad    = bus.Address[0];
            end
            2'b10: begin
              last_d = 2'd3;
              wsh_d  = bus.DataIn;
              bad    = |bus.Address[1:0];
            end
            default: bad = 1'b1;
          endcase
          err_d   = bad;
          state_d = bad ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        // RAM returns a byte one cycle after its strobe, so capture lags issue by one.
        if (rw_q && (cnt_q != 2'd0)) asm_d = {asm_q[23:0], bus.ram_rdata};
        wsh_d = {wsh_q[23:0], 8'h00};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_q) state_d = rw_q ? DRAIN : DONE;
      end
      DRAIN: begin
        dout_d  = {asm_q[23:0], bus.ram_rdata};
        state_d = DONE;
      end
      DONE: begin
        if (!bus.MFA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.DataOut   = dout_q;
  assign bus.MOC       = (state_q == DONE);
  assign bus.AlignErr  = (state_q == DONE) && err_q;
  assign bus.Busy      = (state_q != IDLE);
  assign bus.ram_re    = (state_q == ACCESS) && rw_q;
  assign bus.ram_we    = (state_q == ACCESS) && !rw_q;
  assign bus.ram_addr  = (state_q == ACCESS) ? addr_q + ADDR_W'(cnt_q) : '0;
  assign bus.ram_wdata = bus.ram_we ? wsh_q[31:24] : 8'h00;

endmodule
